pipe_latch: RTL

PIPE_LATCH -- requirements
Module: pipe_latch

---
 rtl/pipe_latch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_latch.sv
// Pipeline latch between two stages: a main register M that always drives the
// outputs, plus an optional skid register S so in_ready can be a pure flop.
module pipe_latch #(
   parameter int                DATA_W   = 160,
   parameter int                CTRL_W   = 16,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
   parameter int                SKID     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [15:0]       stall_cycles
);

   logic              r_m_valid, r_s_valid, r_in_ready;
   logic [DATA_W-1:0] r_m_data, r_s_data;
   logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
   logic [1:0]        r_occupancy;
   logic [15:0]       r_stall;

   logic              w_m_valid_nxt, w_s_valid_nxt;
   logic [DATA_W-1:0] w_m_data_nxt, w_s_data_nxt;
   logic [CTRL_W-1:0] w_m_ctrl_nxt, w_s_ctrl_nxt;
   logic              w_accept, w_m_free, w_stall;

   assign in_ready  = (SKID != 0) ? r_in_ready : (out_ready | ~r_m_valid);
   assign w_accept  = in_valid & in_ready;
   assign w_m_free  = ~r_m_valid | out_ready;
   assign w_stall   = r_m_valid & ~out_ready;

   always_comb begin
      w_m_valid_nxt = r_m_valid;
      w_m_data_nxt  = r_m_data;
      w_m_ctrl_nxt  = r_m_ctrl;
      w_s_valid_nxt = r_s_valid;
      w_s_data_nxt  = r_s_data;
      w_s_ctrl_nxt  = r_s_ctrl;
      if (flush) begin
         w_m_valid_nxt = 1'b0;
         w_m_data_nxt  = '0;
         w_m_ctrl_nxt  = NOP_CTRL;
         w_s_valid_nxt = 1'b0;
         w_s_data_nxt  = '0;
         w_s_ctrl_nxt  = NOP_CTRL;
      end else if (SKID != 0) begin
         if (w_m_free) begin
            if (r_s_valid) begin
               // S is older than anything arriving now, so it moves up first
               w_m_valid_nxt = 1'b1;
               w_m_data_nxt  = r_s_data;
               w_m_ctrl_nxt  = r_s_ctrl;
               w_s_valid_nxt = w_accept;
               if (w_accept) begin
                  w_s_data_nxt = in_data;
                  w_s_ctrl_nxt = in_ctrl;
               end
            end else if (w_accept) begin
               w_m_valid_nxt = 1'b1;
               w_m_data_nxt  = in_data;
               w_m_ctrl_nxt  = in_ctrl;
            end else begin
               w_m_valid_nxt = 1'b0;
            end
         end else if (w_accept) begin
            w_s_valid_nxt = 1'b1;
            w_s_data_nxt  = in_data;
            w_s_ctrl_nxt  = in_ctrl;
         end
      end else begin
         if (w_accept) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = in_data;
            w_m_ctrl_nxt  = in_ctrl;
         end else if (w_m_free) begin
            w_m_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_ctrl    <= NOP_CTRL;
         r_s_valid   <= 1'b0;
         r_s_data    <= '0;
         r_s_ctrl    <= NOP_CTRL;
         r_in_ready  <= 1'b1;
         r_occupancy <= 2'd0;
         r_stall     <= 16'd0;
      end else begin
         r_m_valid   <= w_m_valid_nxt;
         r_m_data    <= w_m_data_nxt;
         r_m_ctrl    <= w_m_ctrl_nxt;
         r_s_valid   <= w_s_valid_nxt;
         r_s_data    <= w_s_data_nxt;
         r_s_ctrl    <= w_s_ctrl_nxt;
         r_in_ready  <= ~w_s_valid_nxt;
         r_occupancy <= {1'b0, w_m_valid_nxt} + {1'b0, w_s_valid_nxt};
         if (w_stall && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
      end
   end

   assign out_valid    = r_m_valid;
   assign out_data     = r_m_data;
   assign out_ctrl     = r_m_valid ? r_m_ctrl : NOP_CTRL;
   assign occupancy    = r_occupancy;
   assign stall_cycles = r_stall;

endmodule
